// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port of the UART program loader.
//
// Signals:
//   imem_we     one-cycle write strobe
//   imem_addr   word address of the current write (ADDR_WIDTH bits)
//   imem_wdata  assembled 32-bit instruction word
//
// Modports:
//   master  the loader, which drives the write port
//   slave   the instruction memory, which consumes it
interface uart_imem_loader_if #(
   parameter int unsigned ADDR_WIDTH = 5
);

   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      input imem_we,
      input imem_addr,
      input imem_wdata
   );

endinterface

// File: rtl/uart_imem_loader.sv
// UART (8N1) receiver and little-endian word assembler feeding the CPU
// instruction memory. Bytes are packed into 32-bit words. Each word is written
// to consecutive addresses. The CPU is held until INSTR_MEM_DEPTH words have
// been written.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   uart_rx    raw serial input; idle high; asynchronous to clk
//   imem       instruction-memory write port (master modport)
//   load_done  sticky; set with the strobe that writes the last address
//   cpu_hold   ~load_done; drives the CPU reset/stall
//   frame_err  sticky; set on any stop bit sampled low
module uart_imem_loader #(
   parameter int unsigned CLKS_PER_BIT    = 434,
   parameter int unsigned INSTR_MEM_DEPTH = 32,
   parameter int unsigned ADDR_WIDTH      = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                uart_rx,
   uart_imem_loader_if.master  imem,
   output logic                load_done,
   output logic                cpu_hold,
   output logic                frame_err
);

   localparam logic [15:0]           BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0]           HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(INSTR_MEM_DEPTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_t;

   // Two-flop synchroniser; both flops reset to the idle (high) level.
   logic sync1_q;
   logic rx_s_q;

   state_t                state_q,     state_d;
   logic [15:0]           timer_q,     timer_d;
   logic [2:0]            bit_cnt_q,   bit_cnt_d;
   logic [7:0]            shift_q,     shift_d;
   // The line must be seen high in IDLE before a new start bit is accepted,
   // so a line held low after a framing error cannot retrigger the receiver.
   logic                  armed_q,     armed_d;
   logic [1:0]            byte_idx_q,  byte_idx_d;
   // Only bytes 0..2 are stored; byte 3 is merged straight into the write data.
   logic [23:0]           word_q,      word_d;
   logic                  we_q,        we_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [31:0]           wdata_q,     wdata_d;
   logic [ADDR_WIDTH-1:0] word_cnt_q,  word_cnt_d;
   logic                  load_done_q, load_done_d;
   logic                  frame_err_q, frame_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b0;
         byte_idx_q  <= '0;
         word_q      <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         word_cnt_q  <= '0;
         load_done_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         word_cnt_q  <= word_cnt_d;
         load_done_q <= load_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      armed_d     = armed_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      word_cnt_d  = word_cnt_q;
      load_done_d = load_done_q;
      frame_err_d = frame_err_q;

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (rx_s_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = StStart;
            end
         end

         StStart: begin
            if (timer_q == HALF_LAST) begin
               timer_d   = '0;
               bit_cnt_d = '0;
               // A start bit that is high again at mid-bit was a glitch.
               state_d   = rx_s_q ? StIdle : StData;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         StData: begin
            if (timer_q == BIT_LAST) begin
               timer_d   = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         StStop: begin
            if (timer_q == BIT_LAST) begin
               timer_d = '0;
               state_d = StIdle;
               armed_d = 1'b0;
               if (!rx_s_q) begin
                  // Bad frame: drop the byte and any partially built word.
                  frame_err_d = 1'b1;
                  byte_idx_d  = '0;
               end else if (!load_done_q) begin
                  unique case (byte_idx_q)
                     2'd0: word_d[7:0]   = shift_q;
                     2'd1: word_d[15:8]  = shift_q;
                     2'd2: word_d[23:16] = shift_q;
                     2'd3: begin
                        we_d    = 1'b1;
                        addr_d  = word_cnt_q;
                        wdata_d = {shift_q, word_q};
                        if (word_cnt_q == ADDR_LAST) begin
                           // Count saturates here; load_done blocks further writes.
                           load_done_d = 1'b1;
                        end else begin
                           word_cnt_d = word_cnt_q + 1'b1;
                        end
                     end
                     default: ;
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   assign imem.imem_we    = we_q;
   assign imem.imem_addr  = addr_q;
   assign imem.imem_wdata = wdata_q;
   assign load_done       = load_done_q;
   assign cpu_hold        = ~load_done_q;
   assign frame_err       = frame_err_q;

endmodule
